ring_meas_ctrl: RTL
===================

Name: ring_meas_ctrl

Overview:
- Synchronous controller that sequences one free-running ring oscillator instance for frequency measurement.
- Holds the ring in reset while idle. On request it releases the ring, waits a settle window, then counts ring transitions over a fixed gate window of clk cycles.
- Presents the count through a valid/ready result handshake.
- Sits between the clocked test/config logic and the asynchronous ring macro. The ring's ack output is treated as an async oscillating input.

Parameters:
- GATE_CYC, 1024, length of the measurement gate in clk cycles (>=1).
- SETTLE_CYC, 16, clk cycles between ring release and gate start (>=1).
- CNT_W, 16, width of the edge counter and result.
- SYNC_STAGES, 2, flops in the ring-input synchronizer (>=2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  measurement request; sampled only in IDLE.
- abort_i  input  1  cancel current measurement; highest priority after reset.
- ring_ack_i  input  1  ring oscillator tap (async).
- ring_rst_o  output  1  active-high reset to ring; 1 = ring held.
- busy_o  output  1  high in SETTLE, MEASURE and DONE.
- res_valid_o  output  1  result valid.
- res_ready_i  input  1  result consumer ready.
- res_cnt_o  output  CNT_W  measured rising-edge count.
- res_ovf_o  output  1  counter saturated during gate.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, ring_rst_o=1, busy_o=0, res_valid_o=0, res_cnt_o=0, res_ovf_o=0, synchronizer flops=0, counters=0.
- Synchronizer: SYNC_STAGES-flop chain on ring_ack_i. Edge pulse = synced & !synced_d (one extra flop). Input-to-pulse latency is SYNC_STAGES+1 cycles.
- The ring frequency must be below clk/2 for an exact count; faster rings alias and are undefined.
- FSM states: IDLE, SETTLE, MEASURE, DONE.
- IDLE:
  - ring_rst_o=1.
  - If start_i=1: go to SETTLE, load settle counter with SETTLE_CYC-1, clear edge counter and ovf.
- SETTLE:
  - ring_rst_o=0.
  - Decrement settle counter each cycle. At 0, go to MEASURE and load gate counter with GATE_CYC-1.
  - Total time in SETTLE is exactly SETTLE_CYC cycles.
- MEASURE:
  - ring_rst_o=0.
  - On every cycle in MEASURE with edge pulse=1, edge counter increments. MEASURE lasts exactly GATE_CYC cycles.
  - Saturation: at 2^CNT_W-1 the counter holds and ovf is set sticky.
  - When the gate counter reaches 0, that cycle's edge still counts. Next cycle: DONE, res_cnt_o/res_ovf_o latched.
- DONE:
  - ring_rst_o=1 (ring stopped on entry).
  - res_valid_o=1, and res_cnt_o/res_ovf_o stay stable while valid.
  - Transfer occurs when res_valid_o & res_ready_i; next state is IDLE, res_valid_o=0, and res_cnt_o keeps its last value.
- start_i asserted outside IDLE is ignored (no queueing). start_i in the same cycle as a DONE transfer is ignored; the next start is accepted in IDLE.
- abort_i=1 in any state:
  - Next state is IDLE, ring_rst_o=1, res_valid_o=0.
  - No result is produced; res_cnt_o is unchanged.
  - abort_i beats start_i in the same cycle.
- Reset mid-measurement behaves like abort but also clears res_cnt_o.
- busy_o = (state != IDLE), registered with the state.

Optional Feature:
- Macro: RING_MEAS_AVG4_EN.
- Defined:
  - One start runs four consecutive SETTLE+MEASURE passes. The ring is reset for 1 cycle between passes.
  - Counts are accumulated in a CNT_W+2 accumulator. res_cnt_o = accumulator >> 2 (truncating).
  - res_ovf_o = OR of all passes' ovf.
  - abort_i discards partial accumulation.
- Undefined: single pass as above; no accumulator logic is present.

Decomposition:
- Shared package ring_pkg: enum ring_meas_state_t {IDLE, SETTLE, MEASURE, DONE} and the default constants for GATE_CYC/SETTLE_CYC.
- One natural sub-module: sync_edge_det (SYNC_STAGES synchronizer plus rising-edge pulse). It is reusable for the other async-to-clk crossings in the design.

Test Plan:
- Basic count:
  - Stimulus: GATE_CYC=100, SETTLE_CYC=4; model drives ring_ack_i toggling every 5 clk while ring_rst_o=0, aligned to clk; pulse start_i.
  - Response: ring_rst_o falls 1 cycle later; res_valid_o rises 105 cycles after start accept; res_cnt_o=10, res_ovf_o=0.
- Backpressure:
  - Stimulus: same as basic count, but hold res_ready_i=0 for 20 cycles.
  - Response: res_valid_o, res_cnt_o=10 stable, ring_rst_o=1 throughout; IDLE the cycle after res_ready_i=1.
- Saturation:
  - Stimulus: CNT_W=3, ring toggling every 2 clk, GATE_CYC=64.
  - Response: res_cnt_o=7, res_ovf_o=1.
- Abort:
  - Stimulus: abort_i at MEASURE cycle 30 together with start_i.
  - Response: IDLE next cycle, ring_rst_o=1, no res_valid_o pulse, previous res_cnt_o retained; a new start then yields 10.
- Async reset:
  - Stimulus: rst_n low mid-SETTLE, not clock-aligned.
  - Response: ring_rst_o=1 and busy_o=0 immediately; res_cnt_o=0.
- AVG4 build:
  - Stimulus: RING_MEAS_AVG4_EN defined; pass counts 10,10,11,12 via varying toggle periods.
  - Response: res_cnt_o=10 (43>>2), single res_valid_o.

Source files
------------

// File: rtl/ring_pkg.sv
// -----------------------------------------------------------------------------
// ring_pkg
// Shared types and default constants for the ring-oscillator measurement slice.
//   ring_meas_state_t : controller state (IDLE, SETTLE, MEASURE, DONE)
//   *_DEF             : default parameter values for ring_meas_ctrl
// -----------------------------------------------------------------------------
package ring_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      MEASURE = 2'd2,
      DONE    = 2'd3
   } ring_meas_state_t;

   localparam int GATE_CYC_DEF    = 1024;
   localparam int SETTLE_CYC_DEF  = 16;
   localparam int CNT_W_DEF       = 16;
   localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Multi-flop synchronizer for an asynchronous level, followed by a rising-edge
// detector. The pulse is one clk wide and appears STAGES+1 clk edges after the
// input change is first sampled when consumed by a register.
// Ports:
//   clk     : sampling clock
//   rst_n   : asynchronous active-low reset, clears all flops
//   async_i : asynchronous input level
//   rise_o  : one-cycle pulse on a synchronized 0->1 transition
// -----------------------------------------------------------------------------
module sync_edge_det #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic rise_o
);

   logic [STAGES-1:0] sync_q;
   logic              level_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         level_d <= 1'b0;
      end else begin
         sync_q  <= {sync_q[STAGES-2:0], async_i};
         level_d <= sync_q[STAGES-1];
      end
   end

   assign rise_o = sync_q[STAGES-1] & ~level_d;

endmodule

// File: rtl/ring_meas_ctrl.sv
// -----------------------------------------------------------------------------
// ring_meas_ctrl
// Sequences one free-running ring oscillator for a frequency measurement:
// holds the ring in reset while idle, releases it on request, waits a settle
// window, counts synchronized rising edges over a fixed gate of clk cycles and
// offers the count on a valid/ready result port.
//
// Build option: define RING_MEAS_AVG4_EN to run four settle+measure passes per
// start (ring reset for one cycle between passes) and report the truncated
// average of the four counts; ovf is the OR over all passes.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start_i       : measurement request, only looked at in IDLE
//   abort_i       : cancel, returns to IDLE with no result (beats start_i)
//   ring_ack_i    : asynchronous ring oscillator tap
//   ring_rst_o    : active-high ring reset (1 = ring held), registered
//   busy_o        : high whenever not IDLE, registered with the state
//   res_valid_o   : result valid
//   res_ready_i   : result consumer ready
//   res_cnt_o     : measured rising-edge count (saturating)
//   res_ovf_o     : counter saturated during the gate
//   dbg_state_o   : current controller state
//
// Result handshake: res_valid_o rises on entry to DONE and stays high, with
// res_cnt_o/res_ovf_o frozen, until a cycle in which res_ready_i is also high;
// that cycle is the transfer and res_valid_o is low from the next cycle on.
// res_valid_o never depends combinationally on res_ready_i.
// -----------------------------------------------------------------------------
module ring_meas_ctrl
   import ring_pkg::*;
#(
   parameter int GATE_CYC    = GATE_CYC_DEF,
   parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic             ring_ack_i,
   output logic             ring_rst_o,
   output logic             busy_o,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [CNT_W-1:0] res_cnt_o,
   output logic             res_ovf_o,
   output ring_meas_state_t dbg_state_o
);

   localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int GAT_W = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
   localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SETTLE_CYC - 1);
   localparam logic [GAT_W-1:0] GATE_INIT   = GAT_W'(GATE_CYC - 1);

   ring_meas_state_t state, state_nxt;

   logic [SET_W-1:0] settle_cnt;
   logic [GAT_W-1:0] gate_cnt;
   logic [CNT_W-1:0] edge_cnt, edge_cnt_nxt;
   logic             ovf_q, ovf_nxt;
   logic [CNT_W-1:0] res_cnt_q;
   logic             res_ovf_q;

   logic ring_rst_q, busy_q, valid_q;
   logic ring_rst_d, busy_d, valid_d;

   logic ring_rise;
   logic edge_inc;
   logic settle_hold;
   logic settle_done;
   logic pass_last;
   logic gap_nxt;

   sync_edge_det #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (ring_ack_i),
      .rise_o  (ring_rise)
   );

`ifdef RING_MEAS_AVG4_EN
   logic [1:0]       pass_q;
   logic [CNT_W+1:0] acc_q;
   logic [CNT_W+1:0] acc_sum;
   logic             gap_q;

   assign pass_last   = (pass_q == 2'd3);
   // One-cycle ring reset between passes; the settle countdown waits it out.
   assign settle_hold = gap_q;
   // SETTLE is only entered from MEASURE when another pass follows.
   assign gap_nxt     = (state == MEASURE);
   assign acc_sum     = acc_q + {2'b00, edge_cnt_nxt};
`else
   assign pass_last   = 1'b1;
   assign settle_hold = 1'b0;
   assign gap_nxt     = 1'b0;
`endif

   assign settle_done = ~settle_hold & (settle_cnt == '0);

   // The last gate cycle's edge still counts, so the result takes the
   // incremented value. Saturate at all-ones; ovf records a lost edge.
   assign edge_inc     = ring_rise & (state == MEASURE);
   assign edge_cnt_nxt = (edge_inc & ~(&edge_cnt)) ? edge_cnt + 1'b1 : edge_cnt;
   assign ovf_nxt      = ovf_q | (edge_inc & (&edge_cnt));

   // State register plus registered outputs (glitch-free ring reset).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ring_rst_q <= 1'b1;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         state      <= state_nxt;
         ring_rst_q <= ring_rst_d;
         busy_q     <= busy_d;
         valid_q    <= valid_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      if (abort_i) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start_i) state_nxt = SETTLE;
            SETTLE:  if (settle_done) state_nxt = MEASURE;
            MEASURE: if (gate_cnt == '0) state_nxt = pass_last ? DONE : SETTLE;
            DONE:    if (res_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Output decode of the upcoming state, registered above.
   always_comb begin
      ring_rst_d = 1'b1;
      busy_d     = 1'b1;
      valid_d    = 1'b0;
      case (state_nxt)
         IDLE:    busy_d     = 1'b0;
         SETTLE:  ring_rst_d = gap_nxt;
         MEASURE: ring_rst_d = 1'b0;
         DONE:    valid_d    = 1'b1;
         default: busy_d     = 1'b0;
      endcase
   end

   // Counters and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt <= '0;
         gate_cnt   <= '0;
         edge_cnt   <= '0;
         ovf_q      <= 1'b0;
         res_cnt_q  <= '0;
         res_ovf_q  <= 1'b0;
`ifdef RING_MEAS_AVG4_EN
         pass_q     <= '0;
         acc_q      <= '0;
         gap_q      <= 1'b0;
`endif
      end else if (abort_i) begin
         // Abort leaves the last delivered result in place.
`ifdef RING_MEAS_AVG4_EN
         pass_q     <= '0;
         acc_q      <= '0;
         gap_q      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  settle_cnt <= SETTLE_INIT;
                  edge_cnt   <= '0;
                  ovf_q      <= 1'b0;
`ifdef RING_MEAS_AVG4_EN
                  pass_q     <= '0;
                  acc_q      <= '0;
                  gap_q      <= 1'b0;
`endif
               end
            end
            SETTLE: begin
               if (settle_done) begin
                  gate_cnt <= GATE_INIT;
               end else if (!settle_hold) begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
`ifdef RING_MEAS_AVG4_EN
               gap_q <= 1'b0;
`endif
            end
            MEASURE: begin
               edge_cnt <= edge_cnt_nxt;
               ovf_q    <= ovf_nxt;
               if (gate_cnt != '0) begin
                  gate_cnt <= gate_cnt - 1'b1;
               end else begin
`ifdef RING_MEAS_AVG4_EN
                  if (pass_last) begin
                     res_cnt_q <= acc_sum[CNT_W+1:2];
                     res_ovf_q <= ovf_nxt;
                  end else begin
                     // ovf stays sticky across passes.
                     acc_q      <= acc_sum;
                     pass_q     <= pass_q + 1'b1;
                     edge_cnt   <= '0;
                     settle_cnt <= SETTLE_INIT;
                     gap_q      <= 1'b1;
                  end
`else
                  res_cnt_q <= edge_cnt_nxt;
                  res_ovf_q <= ovf_nxt;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign ring_rst_o  = ring_rst_q;
   assign busy_o      = busy_q;
   assign res_valid_o = valid_q;
   assign res_cnt_o   = res_cnt_q;
   assign res_ovf_o   = res_ovf_q;
   assign dbg_state_o = state;

endmodule
